core_hazard_scbd: RTL and testbench
===================================

# core_hazard_scbd

Parametrised successor hazard unit for the Selen core pipeline: IF/DEC, DEC/EXE, EXE/MEM and MEM/WB.
- Replaces fixed load-use and jump sequencing with a register scoreboard, so loads may return out of order or with multi-cycle latency.
- Adds an explicit redirect/flush state machine and saturating stall counters.
- Generates forwarding selects for any number of EXE source operands.
- Sits beside the pipeline registers and drives their enable/kill buses, the PC stop, NOP insertion and PC-redirect mux.

## Interface
- NREG, 32: architectural register count; index width AW = $clog2(NREG); register 0 is hardwired zero.
- NSRC, 2: source operands per instruction, checked at DEC and forwarded at EXE.
- FLUSH_CYC, 1: cycles the flush state holds kill on the younger stages after a redirect (1..7).
- CNT_W, 16: width of the saturating stall counters.
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- dec_vld_in  in  1  valid instruction in DEC.
- dec_rs_in  in  NSRC*AW  DEC sources; operand k is in bits [k*AW +: AW].
- dec_rs_vld_in  in  NSRC  per-source "operand used".
- dec_rd_in  in  AW  DEC destination register.
- dec_is_load_in  in  1  DEC instruction is a load.
- exe_rs_in  in  NSRC*AW  EXE sources, same packing as dec_rs_in.
- exe_rd_in / mem_rd_in / wb_rd_in  in  AW  destinations per stage.
- exe_we_in / mem_we_in / wb_we_in  in  1  register-file write enable per stage.
- exe_jump_in  in  1  EXE holds a jump.
- exe_brnch_in  in  1  EXE holds a branch.
- exe_brnch_tkn_in  in  1  ALU taken flag.
- ld_ret_vld_in  in  1  load data returned this cycle.
- ld_ret_rd_in  in  AW  destination of the returned load.
- stall_dec_in  in  1  icache stall.
- stall_wb_in  in  1  dcache stall.
- haz_enb_bus_out  out  4  per-register enable; bit 0 IF/DEC … bit 3 MEM/WB.
- haz_kill_bus_out  out  4  per-register kill, same indexing.
- haz_pc_stop_out  out  1  PC hold.
- haz_nop_gen_out  out  1  insert NOP into DEC/EXE.
- haz_mux_trn_out  out  1  select redirect target for the PC.
- haz_fwd_sel_out  out  NSRC*2  per EXE operand: 0 regfile, 1 MEM, 2 WB, 3 reserved.
- haz_scbd_out  out  NREG  pending-load bitmap (debug).
- haz_stall_cnt_out  out  CNT_W  load-interlock stall cycles.
- haz_flush_cnt_out  out  CNT_W  redirects taken.

## Operation
- **Forwarding (combinational)**
  - Per operand k, if exe_rs[k] != 0:
    - select MEM when mem_we && mem_rd == exe_rs[k];
    - else select WB when wb_we && wb_rd == exe_rs[k];
    - else select regfile.
  - MEM has priority over WB.
- **Scoreboard (registered, NREG bits)**
  - Issue = dec_vld && dec_is_load && enb[1] && !kill[1]. Issue sets bit dec_rd (bit 0 is never set).
  - ld_ret_vld clears bit ld_ret_rd.
  - If set and clear hit the same register in the same cycle, set wins.
- **Interlock**
  - Condition: dec_vld and any used source has its scoreboard bit set, OR dec_rd has its bit set (WAW).
  - Response:
    - enb[0] = 0 and pc_stop = 1;
    - nop_gen = 1;
    - stall counter +1 per cycle.
- **FSM states RUN, FLUSH, WSTALL**
  - RUN:
    - redirect (exe_jump, or exe_brnch && exe_brnch_tkn) → mux_trn = 1, kill[1:0] = 2'b11, load flush counter with FLUSH_CYC-1, flush count +1;
    - go to FLUSH if FLUSH_CYC > 1, else stay in RUN.
  - FLUSH:
    - kill[0] = 1 and nop_gen = 1;
    - counter decrements; at 0 return to RUN;
    - further redirects are ignored.
  - WSTALL:
    - entered from any state when stall_wb_in = 1;
    - enb = 4'b0000, pc_stop = 1, kill = 4'b0000;
    - the flush counter is frozen and the scoreboard is still updated by ld_ret;
    - on stall_wb_in = 0, return to the saved state (RUN or FLUSH).
- **Priority (high → low):** stall_wb > redirect/FLUSH > stall_dec > interlock.
  - stall_dec forces enb[0] = 0, nop_gen = 1 and pc_stop = 1.
  - An interlock during a redirect is dropped; the killed DEC instruction does not count as a stall.
- **Base outputs:** enb = 4'b1111, kill = 4'b0000, pc_stop = ~&enb.
- **Counters:** saturate at all-ones and never wrap.

## Timing
- Reset (async, active-low) values:
  - FSM = RUN;
  - scoreboard = 0;
  - counters = 0;
  - enb = 4'b0000, kill = 4'b1111, nop_gen = 0, mux_trn = 0, fwd_sel = 0, pc_stop = 1.
- Outputs are combinational from inputs and state, with zero-cycle latency.
- A scoreboard set or clear is visible in the interlock on the next cycle.
- A load return in cycle N releases a dependent DEC instruction in cycle N+1.
- Redirect: mux_trn and kill pulse exactly one cycle, followed by FLUSH_CYC-1 FLUSH cycles.
- Reset mid-FLUSH or mid-WSTALL returns directly to reset values.
- Pending scoreboard bits are discarded on reset.

## Structure
- Package core_hazard_pkg holds:
  - FSM state enum;
  - FWD_RF/FWD_MEM/FWD_WB codes;
  - REG_IF_DEC … REG_MEM_WB stage indices;
  - ENB_FULL_ON/OFF and KILL_FULL_ON/OFF constants.
- One sub-module, core_haz_fwd_sel: a per-operand forwarding comparator instantiated NSRC times in a generate loop.

## Test plan
- **Load-use stall:** load x5 issues, next DEC reads x5, return 3 cycles later.
  - Required: enb[0] = 0 and nop_gen = 1 for 3 cycles, released the cycle after the return; stall_cnt = 3.
- **Forwarding priority:** mem_rd = wb_rd = exe_rs[0] = 7 with both writes enabled → fwd_sel[1:0] = 1.
- **Forwarding to x0:** exe_rs = 0 → fwd_sel[1:0] = 0 whatever the other stages hold.
- **Redirect with FLUSH_CYC = 3:**
  - taken branch → one cycle of mux_trn = 1 and kill = 4'b0011, then 2 cycles of kill = 4'b0001;
  - flush_cnt = 1;
  - a second branch during FLUSH is ignored.
- **dcache stall inside FLUSH:** stall_wb held 4 cycles mid-flush.
  - Required: enb = 0 throughout, remaining flush cycles resume after release, and ld_ret still clears its bit.
- **Scoreboard edges:** simultaneous issue and return on x9 leaves bit 9 set; a load to x0 leaves the scoreboard at 0.
- **Async reset:** assert rst_n mid-interlock → outputs take their reset values without a clock edge.

Source files
------------

// File: rtl/core_hazard_pkg.sv
// Shared state encoding, forwarding codes and bus constants for the
// core hazard scoreboard and its forwarding comparators.
package core_hazard_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_WSTALL = 2'd2
   } haz_state_e;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

   localparam int REG_IF_DEC  = 0;
   localparam int REG_DEC_EXE = 1;
   localparam int REG_EXE_MEM = 2;
   localparam int REG_MEM_WB  = 3;

   localparam logic [3:0] ENB_FULL_ON   = 4'b1111;
   localparam logic [3:0] ENB_FULL_OFF  = 4'b0000;
   localparam logic [3:0] KILL_FULL_ON  = 4'b1111;
   localparam logic [3:0] KILL_FULL_OFF = 4'b0000;

endpackage

// File: rtl/core_haz_fwd_sel.sv
// Forwarding select for one EXE source operand; MEM beats WB and x0
// always reads the register file.
module core_haz_fwd_sel
   import core_hazard_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic [AW-1:0] exe_rs,
   input  logic [AW-1:0] mem_rd,
   input  logic          mem_we,
   input  logic [AW-1:0] wb_rd,
   input  logic          wb_we,
   output logic [1:0]    fwd_sel
);

   always_comb begin
      fwd_sel = FWD_RF;
      if (exe_rs != '0) begin
         if (mem_we && (mem_rd == exe_rs)) begin
            fwd_sel = FWD_MEM;
         end else if (wb_we && (wb_rd == exe_rs)) begin
            fwd_sel = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/core_hazard_scbd.sv
// Pipeline hazard unit: pending-load scoreboard interlock, redirect/flush
// sequencing, dcache-stall freeze, forwarding selects and stall counters.
module core_hazard_scbd
   import core_hazard_pkg::*;
#(
   parameter  int NREG      = 32,
   parameter  int NSRC      = 2,
   parameter  int FLUSH_CYC = 1,
   parameter  int CNT_W     = 16,
   localparam int AW        = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                dec_vld_in,
   input  logic [NSRC*AW-1:0]  dec_rs_in,
   input  logic [NSRC-1:0]     dec_rs_vld_in,
   input  logic [AW-1:0]       dec_rd_in,
   input  logic                dec_is_load_in,
   input  logic [NSRC*AW-1:0]  exe_rs_in,
   input  logic [AW-1:0]       exe_rd_in,
   input  logic [AW-1:0]       mem_rd_in,
   input  logic [AW-1:0]       wb_rd_in,
   input  logic                exe_we_in,
   input  logic                mem_we_in,
   input  logic                wb_we_in,
   input  logic                exe_jump_in,
   input  logic                exe_brnch_in,
   input  logic                exe_brnch_tkn_in,
   input  logic                ld_ret_vld_in,
   input  logic [AW-1:0]       ld_ret_rd_in,
   input  logic                stall_dec_in,
   input  logic                stall_wb_in,
   output logic [3:0]          haz_enb_bus_out,
   output logic [3:0]          haz_kill_bus_out,
   output logic                haz_pc_stop_out,
   output logic                haz_nop_gen_out,
   output logic                haz_mux_trn_out,
   output logic [NSRC*2-1:0]   haz_fwd_sel_out,
   output logic [NREG-1:0]     haz_scbd_out,
   output logic [CNT_W-1:0]    haz_stall_cnt_out,
   output logic [CNT_W-1:0]    haz_flush_cnt_out
);

   haz_state_e        state_q, state_d, saved_q, saved_d, eff_state;
   logic [2:0]        fcnt_q, fcnt_d;
   logic [NREG-1:0]   scbd_q, scbd_d;
   logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
   logic [3:0]        enb, kill;
   logic              nop_gen, mux_trn;
   logic              redirect, src_hit, interlock, issue;
   logic              stall_inc, flush_inc;
   logic [NSRC*2-1:0] fwd_raw;
   logic              unused_inputs;

   assign unused_inputs = ^{exe_rd_in, exe_we_in};

   for (genvar k = 0; k < NSRC; k++) begin : g_fwd
      core_haz_fwd_sel #(.AW(AW)) u_fwd (
         .exe_rs  (exe_rs_in[k*AW +: AW]),
         .mem_rd  (mem_rd_in),
         .mem_we  (mem_we_in),
         .wb_rd   (wb_rd_in),
         .wb_we   (wb_we_in),
         .fwd_sel (fwd_raw[k*2 +: 2])
      );
   end

   assign redirect  = exe_jump_in || (exe_brnch_in && exe_brnch_tkn_in);
   // WSTALL resumes whatever it interrupted, so decode from the saved state.
   assign eff_state = (state_q == ST_WSTALL) ? saved_q : state_q;

   always_comb begin
      src_hit = 1'b0;
      for (int k = 0; k < NSRC; k++) begin
         if (dec_rs_vld_in[k] && scbd_q[dec_rs_in[k*AW +: AW]]) begin
            src_hit = 1'b1;
         end
      end
      interlock = dec_vld_in && (src_hit || scbd_q[dec_rd_in]);
   end

   always_comb begin
      enb       = ENB_FULL_ON;
      kill      = KILL_FULL_OFF;
      nop_gen   = 1'b0;
      mux_trn   = 1'b0;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      state_d   = state_q;
      saved_d   = saved_q;
      fcnt_d    = fcnt_q;
      if (stall_wb_in) begin
         enb[REG_MEM_WB:REG_IF_DEC] = ENB_FULL_OFF;
         state_d = ST_WSTALL;
         if (state_q != ST_WSTALL) begin
            saved_d = state_q;
         end
      end else if (eff_state == ST_FLUSH) begin
         kill[REG_IF_DEC] = 1'b1;
         nop_gen = 1'b1;
         fcnt_d  = fcnt_q - 3'd1;
         state_d = (fcnt_d == 3'd0) ? ST_RUN : ST_FLUSH;
      end else if (redirect) begin
         mux_trn   = 1'b1;
         kill[REG_DEC_EXE:REG_IF_DEC] = 2'b11;
         flush_inc = 1'b1;
         fcnt_d    = 3'(FLUSH_CYC - 1);
         state_d   = (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;
      end else begin
         state_d = ST_RUN;
         if (stall_dec_in) begin
            enb[REG_IF_DEC] = 1'b0;
            nop_gen = 1'b1;
         end else if (interlock) begin
            enb[REG_IF_DEC] = 1'b0;
            nop_gen   = 1'b1;
            stall_inc = 1'b1;
         end
      end
   end

   // An instruction replaced by a NOP never leaves DEC, so it must not issue.
   assign issue = dec_vld_in && dec_is_load_in && enb[REG_DEC_EXE]
                  && !kill[REG_DEC_EXE] && !nop_gen;

   always_comb begin
      scbd_d = scbd_q;
      if (ld_ret_vld_in) begin
         scbd_d[ld_ret_rd_in] = 1'b0;
      end
      if (issue && (dec_rd_in != '0)) begin
         scbd_d[dec_rd_in] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         saved_q <= ST_RUN;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
         fcnt_q  <= fcnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scbd_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         scbd_q <= scbd_d;
         if (stall_inc && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (flush_inc && !(&flush_cnt_q)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   // Reset drives the pipeline control to its safe values immediately.
   assign haz_enb_bus_out   = rst_n ? enb : ENB_FULL_OFF;
   assign haz_kill_bus_out  = rst_n ? kill : KILL_FULL_ON;
   assign haz_pc_stop_out   = ~&haz_enb_bus_out;
   assign haz_nop_gen_out   = rst_n && nop_gen;
   assign haz_mux_trn_out   = rst_n && mux_trn;
   assign haz_fwd_sel_out   = rst_n ? fwd_raw : '0;
   assign haz_scbd_out      = scbd_q;
   assign haz_stall_cnt_out = stall_cnt_q;
   assign haz_flush_cnt_out = flush_cnt_q;

endmodule

// File: tb/tb_core_hazard_scbd.sv
// Self-checking bench for core_hazard_scbd: forwarding table, directed
// multi-cycle sequences and randomized traffic against a reference model.
module tb_core_hazard_scbd;

   localparam int NREG      = 32;
   localparam int NSRC      = 2;
   localparam int FLUSH_CYC = 3;
   localparam int CNT_W     = 4;
   localparam int CNT_MAX   = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dec_vld_in, dec_is_load_in;
   logic [9:0]  dec_rs_in, exe_rs_in;
   logic [1:0]  dec_rs_vld_in;
   logic [4:0]  dec_rd_in, exe_rd_in, mem_rd_in, wb_rd_in, ld_ret_rd_in;
   logic        exe_we_in, mem_we_in, wb_we_in;
   logic        exe_jump_in, exe_brnch_in, exe_brnch_tkn_in;
   logic        ld_ret_vld_in, stall_dec_in, stall_wb_in;
   logic [3:0]  haz_enb_bus_out, haz_kill_bus_out;
   logic        haz_pc_stop_out, haz_nop_gen_out, haz_mux_trn_out;
   logic [3:0]  haz_fwd_sel_out;
   logic [31:0] haz_scbd_out;
   logic [3:0]  haz_stall_cnt_out, haz_flush_cnt_out;

   int tests = 0;
   int fails = 0;

   bit          pend[NREG];
   int          flush_left, stall_cnt_m, flush_cnt_m;
   bit          ev_stall, ev_redir, ev_issue;
   logic [63:0] exp_vec;

   localparam logic [63:0] RESET_VEC = {9'b0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0,
                                        4'h0, 32'h0, 4'h0, 4'h0};

   typedef struct {
      logic [4:0] rs0, rs1, mem_rd;
      logic       mem_we;
      logic [4:0] wb_rd;
      logic       wb_we;
      logic [3:0] exp_fwd;
   } fwd_vec_t;

   fwd_vec_t fwd_tab[8];

   core_hazard_scbd #(
      .NREG(NREG), .NSRC(NSRC), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .dec_vld_in(dec_vld_in), .dec_rs_in(dec_rs_in), .dec_rs_vld_in(dec_rs_vld_in),
      .dec_rd_in(dec_rd_in), .dec_is_load_in(dec_is_load_in),
      .exe_rs_in(exe_rs_in), .exe_rd_in(exe_rd_in), .mem_rd_in(mem_rd_in),
      .wb_rd_in(wb_rd_in), .exe_we_in(exe_we_in), .mem_we_in(mem_we_in),
      .wb_we_in(wb_we_in), .exe_jump_in(exe_jump_in), .exe_brnch_in(exe_brnch_in),
      .exe_brnch_tkn_in(exe_brnch_tkn_in), .ld_ret_vld_in(ld_ret_vld_in),
      .ld_ret_rd_in(ld_ret_rd_in), .stall_dec_in(stall_dec_in),
      .stall_wb_in(stall_wb_in),
      .haz_enb_bus_out(haz_enb_bus_out), .haz_kill_bus_out(haz_kill_bus_out),
      .haz_pc_stop_out(haz_pc_stop_out), .haz_nop_gen_out(haz_nop_gen_out),
      .haz_mux_trn_out(haz_mux_trn_out), .haz_fwd_sel_out(haz_fwd_sel_out),
      .haz_scbd_out(haz_scbd_out), .haz_stall_cnt_out(haz_stall_cnt_out),
      .haz_flush_cnt_out(haz_flush_cnt_out)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pack_dut();
      return {9'b0, haz_enb_bus_out, haz_kill_bus_out, haz_pc_stop_out,
              haz_nop_gen_out, haz_mux_trn_out, haz_fwd_sel_out, haz_scbd_out,
              haz_stall_cnt_out, haz_flush_cnt_out};
   endfunction

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (rs == 5'd0) return 2'd0;
      if (mem_we_in && mem_rd_in == rs) return 2'd1;
      if (wb_we_in && wb_rd_in == rs) return 2'd2;
      return 2'd0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) pend[i] = 1'b0;
      flush_left  = 0;
      stall_cnt_m = 0;
      flush_cnt_m = 0;
   endtask

   // Expected outputs for the current inputs, from the model's pending set,
   // remaining flush cycles and counter values.
   task automatic model_eval();
      logic [3:0]  e_enb, e_kill, e_fwd;
      logic        e_nop, e_mux;
      logic [31:0] e_scbd;
      bit          hazard;
      e_enb = 4'hF; e_kill = 4'h0; e_nop = 1'b0; e_mux = 1'b0;
      ev_stall = 1'b0; ev_redir = 1'b0;
      hazard = dec_vld_in && (pend[dec_rd_in]
               || (dec_rs_vld_in[0] && pend[dec_rs_in[4:0]])
               || (dec_rs_vld_in[1] && pend[dec_rs_in[9:5]]));
      if (stall_wb_in) begin
         e_enb = 4'h0;
      end else if (flush_left > 0) begin
         e_kill = 4'b0001; e_nop = 1'b1;
      end else if (exe_jump_in || (exe_brnch_in && exe_brnch_tkn_in)) begin
         e_mux = 1'b1; e_kill = 4'b0011; ev_redir = 1'b1;
      end else if (stall_dec_in) begin
         e_enb = 4'b1110; e_nop = 1'b1;
      end else if (hazard) begin
         e_enb = 4'b1110; e_nop = 1'b1; ev_stall = 1'b1;
      end
      ev_issue = dec_vld_in && dec_is_load_in && e_enb[1] && !e_kill[1] && !e_nop;
      e_fwd = {ref_fwd(exe_rs_in[9:5]), ref_fwd(exe_rs_in[4:0])};
      for (int i = 0; i < NREG; i++) e_scbd[i] = pend[i];
      exp_vec = {9'b0, e_enb, e_kill, (e_enb != 4'hF), e_nop, e_mux, e_fwd,
                 e_scbd, 4'(stall_cnt_m), 4'(flush_cnt_m)};
   endtask

   task automatic model_update();
      if (!stall_wb_in) begin
         if (flush_left > 0) flush_left--;
         else if (ev_redir) flush_left = FLUSH_CYC - 1;
      end
      if (ev_stall && stall_cnt_m < CNT_MAX) stall_cnt_m++;
      if (ev_redir && flush_cnt_m < CNT_MAX) flush_cnt_m++;
      if (ld_ret_vld_in) pend[ld_ret_rd_in] = 1'b0;
      if (ev_issue && dec_rd_in != 5'd0) pend[dec_rd_in] = 1'b1;
   endtask

   task automatic settle(input string tag);
      #3;
      model_eval();
      check_output(tag, pack_dut(), exp_vec);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_update();
   endtask

   task automatic step(input string tag);
      settle(tag);
      tick();
   endtask

   task automatic apply_stimulus();
      dec_vld_in       = 1'b0;
      dec_is_load_in   = 1'b0;
      dec_rs_in        = '0;
      dec_rs_vld_in    = '0;
      dec_rd_in        = '0;
      exe_rs_in        = '0;
      exe_rd_in        = '0;
      mem_rd_in        = '0;
      wb_rd_in         = '0;
      exe_we_in        = 1'b0;
      mem_we_in        = 1'b0;
      wb_we_in         = 1'b0;
      exe_jump_in      = 1'b0;
      exe_brnch_in     = 1'b0;
      exe_brnch_tkn_in = 1'b0;
      ld_ret_vld_in    = 1'b0;
      ld_ret_rd_in     = '0;
      stall_dec_in     = 1'b0;
      stall_wb_in      = 1'b0;
   endtask

   task automatic randomize_inputs();
      dec_vld_in       = ($urandom_range(9, 0) < 7);
      dec_is_load_in   = ($urandom_range(2, 0) == 0);
      dec_rd_in        = 5'($urandom_range(7, 0));
      dec_rs_in        = {5'($urandom_range(7, 0)), 5'($urandom_range(7, 0))};
      dec_rs_vld_in    = 2'($urandom);
      exe_rs_in        = {5'($urandom_range(7, 0)), 5'($urandom_range(7, 0))};
      exe_rd_in        = 5'($urandom);
      exe_we_in        = 1'($urandom);
      mem_rd_in        = 5'($urandom_range(7, 0));
      mem_we_in        = 1'($urandom);
      wb_rd_in         = 5'($urandom_range(7, 0));
      wb_we_in         = 1'($urandom);
      exe_jump_in      = ($urandom_range(19, 0) == 0);
      exe_brnch_in     = ($urandom_range(9, 0) == 0);
      exe_brnch_tkn_in = 1'($urandom);
      ld_ret_vld_in    = ($urandom_range(3, 0) == 0);
      ld_ret_rd_in     = 5'($urandom_range(7, 0));
      stall_dec_in     = ($urandom_range(9, 0) == 0);
      stall_wb_in      = ($urandom_range(11, 0) == 0);
   endtask

   initial begin
      fwd_tab[0] = '{5'd7,  5'd0,  5'd7,  1'b1, 5'd7,  1'b1, 4'b0001};
      fwd_tab[1] = '{5'd0,  5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 4'b0000};
      fwd_tab[2] = '{5'd3,  5'd4,  5'd4,  1'b1, 5'd3,  1'b1, 4'b0110};
      fwd_tab[3] = '{5'd3,  5'd3,  5'd3,  1'b0, 5'd3,  1'b1, 4'b1010};
      fwd_tab[4] = '{5'd12, 5'd12, 5'd12, 1'b0, 5'd12, 1'b0, 4'b0000};
      fwd_tab[5] = '{5'd31, 5'd30, 5'd30, 1'b1, 5'd31, 1'b0, 4'b0100};
      fwd_tab[6] = '{5'd5,  5'd0,  5'd6,  1'b1, 5'd5,  1'b1, 4'b0010};
      fwd_tab[7] = '{5'd0,  5'd9,  5'd9,  1'b1, 5'd9,  1'b1, 4'b0100};

      // Reset with a forwarding match present: selects must still read 0.
      apply_stimulus();
      exe_rs_in = {5'd7, 5'd7}; mem_rd_in = 5'd7; mem_we_in = 1'b1;
      #7;
      check_output("reset_values", pack_dut(), RESET_VEC);
      @(posedge clk); #1;
      check_output("reset_values_clocked", pack_dut(), RESET_VEC);
      rst_n = 1'b1;
      model_reset();
      apply_stimulus();

      for (int i = 0; i < 8; i++) begin
         exe_rs_in = {fwd_tab[i].rs1, fwd_tab[i].rs0};
         mem_rd_in = fwd_tab[i].mem_rd; mem_we_in = fwd_tab[i].mem_we;
         wb_rd_in  = fwd_tab[i].wb_rd;  wb_we_in  = fwd_tab[i].wb_we;
         settle($sformatf("fwd_row%0d_model", i));
         check_output($sformatf("fwd_row%0d", i), 64'(haz_fwd_sel_out),
                      64'(fwd_tab[i].exp_fwd));
         tick();
      end

      // Load-use: load x5, consumer stalls 3 cycles, return on the third.
      apply_stimulus();
      dec_vld_in = 1'b1; dec_is_load_in = 1'b1; dec_rd_in = 5'd5;
      settle("lu_issue");
      check_output("lu_issue_enb", 64'(haz_enb_bus_out), 64'hF);
      tick();
      dec_is_load_in = 1'b0; dec_rd_in = 5'd6;
      dec_rs_in = {5'd0, 5'd5}; dec_rs_vld_in = 2'b01;
      for (int c = 0; c < 3; c++) begin
         ld_ret_vld_in = (c == 2); ld_ret_rd_in = 5'd5;
         settle("lu_stall");
         check_output("lu_stall_enb0", 64'(haz_enb_bus_out[0]), 64'd0);
         check_output("lu_stall_nop", 64'(haz_nop_gen_out), 64'd1);
         check_output("lu_scbd5", 64'(haz_scbd_out[5]), 64'd1);
         tick();
      end
      ld_ret_vld_in = 1'b0;
      settle("lu_release");
      check_output("lu_release_enb", 64'(haz_enb_bus_out), 64'hF);
      check_output("lu_stall_cnt", 64'(haz_stall_cnt_out), 64'd3);
      tick();

      // Taken branch with a second branch held through the flush.
      apply_stimulus();
      exe_brnch_in = 1'b1; exe_brnch_tkn_in = 1'b1;
      settle("br_redirect");
      check_output("br_mux_trn", 64'(haz_mux_trn_out), 64'd1);
      check_output("br_kill", 64'(haz_kill_bus_out), 64'h3);
      tick();
      for (int c = 0; c < 2; c++) begin
         settle("br_flush");
         check_output("br_flush_kill", 64'(haz_kill_bus_out), 64'h1);
         check_output("br_flush_mux", 64'(haz_mux_trn_out), 64'd0);
         check_output("br_flush_cnt", 64'(haz_flush_cnt_out), 64'd1);
         tick();
      end
      apply_stimulus();
      settle("br_done");
      check_output("br_done_kill", 64'(haz_kill_bus_out), 64'h0);
      tick();

      // dcache stall in the middle of a flush, with a load return inside it.
      dec_vld_in = 1'b1; dec_is_load_in = 1'b1; dec_rd_in = 5'd12;
      step("ws_issue");
      apply_stimulus();
      exe_jump_in = 1'b1;
      settle("ws_jump");
      check_output("ws_jump_kill", 64'(haz_kill_bus_out), 64'h3);
      tick();
      exe_jump_in = 1'b0;
      settle("ws_flush1");
      check_output("ws_flush1_kill", 64'(haz_kill_bus_out), 64'h1);
      tick();
      stall_wb_in = 1'b1;
      for (int c = 0; c < 4; c++) begin
         ld_ret_vld_in = (c == 1); ld_ret_rd_in = 5'd12;
         settle("ws_stall");
         check_output("ws_stall_enb", 64'(haz_enb_bus_out), 64'h0);
         check_output("ws_stall_kill", 64'(haz_kill_bus_out), 64'h0);
         check_output("ws_stall_pc", 64'(haz_pc_stop_out), 64'd1);
         tick();
      end
      stall_wb_in = 1'b0; ld_ret_vld_in = 1'b0;
      settle("ws_resume");
      check_output("ws_resume_kill", 64'(haz_kill_bus_out), 64'h1);
      check_output("ws_scbd12", 64'(haz_scbd_out[12]), 64'd0);
      tick();
      settle("ws_after");
      check_output("ws_after_kill", 64'(haz_kill_bus_out), 64'h0);
      check_output("ws_flush_cnt", 64'(haz_flush_cnt_out), 64'd2);
      tick();

      // Same-cycle issue and return on x9, WAW stall, then load to x0.
      apply_stimulus();
      dec_vld_in = 1'b1; dec_is_load_in = 1'b1; dec_rd_in = 5'd9;
      ld_ret_vld_in = 1'b1; ld_ret_rd_in = 5'd9;
      step("sb_set_clr");
      apply_stimulus();
      dec_vld_in = 1'b1; dec_rd_in = 5'd9;
      settle("sb_waw");
      check_output("sb_bit9", 64'(haz_scbd_out[9]), 64'd1);
      check_output("sb_waw_enb0", 64'(haz_enb_bus_out[0]), 64'd0);
      tick();
      apply_stimulus();
      ld_ret_vld_in = 1'b1; ld_ret_rd_in = 5'd9;
      step("sb_clear9");
      apply_stimulus();
      dec_vld_in = 1'b1; dec_is_load_in = 1'b1; dec_rd_in = 5'd0;
      step("sb_load_x0");
      apply_stimulus();
      settle("sb_empty");
      check_output("sb_zero", 64'(haz_scbd_out), 64'd0);
      tick();

      // icache stall: holds DEC but does not count as a load interlock.
      stall_dec_in = 1'b1; dec_vld_in = 1'b1;
      settle("sd_stall");
      check_output("sd_enb", 64'(haz_enb_bus_out), 64'hE);
      check_output("sd_pc_stop", 64'(haz_pc_stop_out), 64'd1);
      tick();

      // Long interlock drives the 4-bit stall counter into saturation.
      apply_stimulus();
      dec_vld_in = 1'b1; dec_is_load_in = 1'b1; dec_rd_in = 5'd20;
      step("sat_issue");
      dec_is_load_in = 1'b0; dec_rd_in = 5'd1;
      dec_rs_in = {5'd20, 5'd0}; dec_rs_vld_in = 2'b10;
      for (int c = 0; c < 14; c++) step("sat_stall");
      settle("sat_check");
      check_output("sat_stall_cnt", 64'(haz_stall_cnt_out), 64'd15);
      tick();
      apply_stimulus();
      ld_ret_vld_in = 1'b1; ld_ret_rd_in = 5'd20;
      step("sat_return");
      apply_stimulus();

      // Asynchronous reset in the middle of an interlock.
      dec_vld_in = 1'b1; dec_is_load_in = 1'b1; dec_rd_in = 5'd5;
      step("ar_issue");
      dec_is_load_in = 1'b0; dec_rd_in = 5'd6;
      dec_rs_in = {5'd0, 5'd5}; dec_rs_vld_in = 2'b01;
      settle("ar_stall");
      check_output("ar_stall_enb", 64'(haz_enb_bus_out), 64'hE);
      #1 rst_n = 1'b0;
      #1 check_output("ar_reset_values", pack_dut(), RESET_VEC);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      apply_stimulus();

      // Randomized traffic against the model, with a reset between blocks.
      for (int blk = 0; blk < 8; blk++) begin
         for (int c = 0; c < 250; c++) begin
            randomize_inputs();
            step($sformatf("rand_b%0d_c%0d", blk, c));
         end
         rst_n = 1'b0;
         #1 check_output("rand_reset", pack_dut(), RESET_VEC);
         rst_n = 1'b1;
         model_reset();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
